// File: rtl/bitrev_reorder_if.sv
// Sample stream between the last SDF stage, the bit-reverse reorder buffer and its consumer.
// Optional bypass control exists only when BITREV_REORDER_BYPASS_EN is defined.
interface bitrev_reorder_if #(parameter int W = 16);
  logic [2*W-1:0] ip;
  logic           start_ip;
  logic [2*W-1:0] op;
  logic           op_valid;
  logic           start_op;
`ifdef BITREV_REORDER_BYPASS_EN
  logic           bypass;
`endif

  modport master (
`ifdef BITREV_REORDER_BYPASS_EN
    output bypass,
`endif
    output ip, start_ip,
    input  op, op_valid, start_op
  );

  modport slave (
`ifdef BITREV_REORDER_BYPASS_EN
    input  bypass,
`endif
    input  ip, start_ip,
    output op, op_valid, start_op
  );
endinterface

// File: rtl/bitrev_reorder.sv
// Ping-pong frame buffer that replays bit-reversed FFT output frames in natural order.
// Defining BITREV_REORDER_BYPASS_EN adds a per-frame bypass (identity read order).
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  bitrev_reorder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << N;
  localparam logic [N-1:0] LAST = '1;

  typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  logic [2*W-1:0] mem [2][DEPTH];

  wr_state_t    wr_state, wr_next;
  logic [N-1:0] wr_cnt, wr_cnt_next, wr_addr;
  logic         wr_bank, we, wr_done;
  logic         fc, fc_bank;

  rd_state_t    rd_state, rd_next;
  logic [N-1:0] rd_cnt, rd_rev, rd_addr;
  logic         rd_bank, rd_bypass;

  // Write side: a start_ip seen mid-fill restarts the frame at address 0 of the same bank.
  always_comb begin
    wr_next     = wr_state;
    wr_cnt_next = wr_cnt;
    wr_addr     = wr_cnt;
    we          = 1'b0;
    wr_done     = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        if (bus.start_ip) begin
          we          = 1'b1;
          wr_addr     = '0;
          wr_cnt_next = {{(N-1){1'b0}}, 1'b1};
          wr_next     = W_FILL;
        end
      end
      W_FILL: begin
        we = 1'b1;
        if (bus.start_ip) begin
          wr_addr     = '0;
          wr_cnt_next = {{(N-1){1'b0}}, 1'b1};
        end else begin
          wr_cnt_next = wr_cnt + 1'b1;
          if (wr_cnt == LAST) begin
            wr_done = 1'b1;
            wr_next = W_IDLE;
          end
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      fc       <= 1'b0;
      fc_bank  <= 1'b0;
    end else begin
      wr_state <= wr_next;
      wr_cnt   <= wr_cnt_next;
      fc       <= wr_done;
      fc_bank  <= wr_bank;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= bus.ip;
  end

  always_comb begin
    rd_rev = '0;
    for (int unsigned i = 0; i < N; i++) rd_rev[i] = rd_cnt[N-1-i];
  end

`ifdef BITREV_REORDER_BYPASS_EN
  assign rd_addr = rd_bypass ? rd_cnt : rd_rev;
`else
  assign rd_addr = rd_rev;
`endif

  // A new frame-complete always wins, so back-to-back frames drain without a gap.
  always_comb begin
    rd_next = rd_state;
    if (fc)                                        rd_next = R_DRAIN;
    else if (rd_state == R_DRAIN && rd_cnt == LAST) rd_next = R_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      rd_cnt       <= '0;
      rd_bank      <= 1'b0;
      rd_bypass    <= 1'b0;
      bus.op       <= '0;
      bus.op_valid <= 1'b0;
      bus.start_op <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (fc) begin
        rd_bank <= fc_bank;
        rd_cnt  <= '0;
`ifdef BITREV_REORDER_BYPASS_EN
        rd_bypass <= bus.bypass;
`else
        rd_bypass <= 1'b0;
`endif
      end else if (rd_state == R_DRAIN) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (rd_state == R_DRAIN) begin
        bus.op       <= mem[rd_bank][rd_addr];
        bus.op_valid <= 1'b1;
        bus.start_op <= (rd_cnt == '0);
      end else begin
        bus.op_valid <= 1'b0;
        bus.start_op <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder (N=3): reorder, back-to-back, abort, reset, extremes, bypass.
module tb_bitrev_reorder;
  localparam int N = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitrev_reorder_if #(.W(W)) bus ();
  bitrev_reorder #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        s;
    int          c;
  } samp_t;
  samp_t q[$];

  always @(negedge clk)
    if (bus.op_valid === 1'b1) q.push_back('{d: bus.op, s: bus.start_op, c: cyc});

  int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [31:0] frame[8];

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start_ip = 1'b0;
      bus.ip       = '0;
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < 8; i++) frame[i] = {16'(base + i), 16'h0000};
  endtask

  // k = value of cyc right after the edge that samples start_ip
  task automatic send_frame(input int len, output int k);
    k = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.start_ip = (i == 0);
      bus.ip       = frame[i];
      if (i == 0) k = cyc + 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start_ip = 1'b0;
    bus.ip = '0;
`ifdef BITREV_REORDER_BYPASS_EN
    bus.bypass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    vectors++; if (bus.op !== 32'h0) begin miscompares++; $display("FAIL reset_op got %h want 0", bus.op); end
    vectors++; if (bus.op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.op_valid); end
    vectors++; if (bus.start_op !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", bus.start_op); end
    rst = 1'b0;
    drive_idle(2);
  endtask

  task automatic test_single;
    int k;
    q.delete();
    fill_ramp(0);
    send_frame(8, k);
    drive_idle(20);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL single_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i].d !== {16'(order[i]), 16'h0} || q[i].s !== (i == 0) || q[i].c !== k + 9 + i) begin
        miscompares++;
        $display("FAIL single[%0d] got d=%h s=%b c=%0d want d=%h s=%b c=%0d",
                 i, q[i].d, q[i].s, q[i].c, {16'(order[i]), 16'h0}, (i == 0), k + 9 + i);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k, k2, e;
    q.delete();
    fill_ramp(0);
    send_frame(8, k);
    fill_ramp(8);
    send_frame(8, k2);
    drive_idle(24);
    vectors++; if (q.size() !== 16) begin miscompares++; $display("FAIL b2b_count got %0d want 16", q.size()); end
    vectors++; if (k2 !== k + 8) begin miscompares++; $display("FAIL b2b_spacing got %0d want %0d", k2, k + 8); end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      e = (i < 8) ? order[i] : 8 + order[i-8];
      vectors++;
      if (q[i].d[31:16] !== 16'(e) || q[i].s !== (i % 8 == 0) || q[i].c !== k + 9 + i) begin
        miscompares++;
        $display("FAIL b2b[%0d] got re=%0d s=%b c=%0d want re=%0d s=%b c=%0d",
                 i, q[i].d[31:16], q[i].s, q[i].c, e, (i % 8 == 0), k + 9 + i);
      end
    end
  endtask

  task automatic test_abort;
    int k, k2;
    q.delete();
    fill_ramp(100);
    send_frame(3, k);
    fill_ramp(0);
    send_frame(8, k2);
    drive_idle(24);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL abort_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i].d[31:16] !== 16'(order[i]) || q[i].c !== k2 + 9 + i) begin
        miscompares++;
        $display("FAIL abort[%0d] got re=%0d c=%0d want re=%0d c=%0d",
                 i, q[i].d[31:16], q[i].c, order[i], k2 + 9 + i);
      end
    end
  endtask

  task automatic test_reset_mid;
    int k, budget;
    q.delete();
    fill_ramp(0);
    send_frame(8, k);
    bus.start_ip = 1'b0;
    budget = 50;
    while (cyc != k + 12 && budget > 0) begin
      drive_idle(1);
      budget--;
    end
    vectors++;
    if (budget == 0 || bus.op_valid !== 1'b1 || bus.op[31:16] !== 16'd6) begin
      miscompares++;
      $display("FAIL rstmid_4th got valid=%b re=%0d want valid=1 re=6", bus.op_valid, bus.op[31:16]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.op !== 32'h0 || bus.op_valid !== 1'b0 || bus.start_op !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_clear got op=%h v=%b s=%b want 0/0/0", bus.op, bus.op_valid, bus.start_op);
    end
    q.delete();
    drive_idle(15);
    vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL rstmid_quiet got %0d outputs want 0", q.size()); end
    fill_ramp(16);
    send_frame(8, k);
    drive_idle(20);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL rstmid_fresh_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i].d[31:16] !== 16'(16 + order[i]) || q[i].c !== k + 9 + i) begin
        miscompares++;
        $display("FAIL rstmid_fresh[%0d] got re=%0d c=%0d want re=%0d c=%0d",
                 i, q[i].d[31:16], q[i].c, 16 + order[i], k + 9 + i);
      end
    end
  endtask

  task automatic test_signed;
    int k;
    q.delete();
    for (int i = 0; i < 8; i++) frame[i] = {16'(i), 16'(16'h00F0 + i)};
    frame[1] = {16'h8000, 16'h7FFF};
    send_frame(8, k);
    drive_idle(20);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL signed_count got %0d want 8", q.size()); end
    vectors++;
    if (q.size() < 5 || q[4].d !== 32'h80007FFF) begin
      miscompares++;
      $display("FAIL signed_extreme got %h want 80007fff", (q.size() > 4) ? q[4].d : 32'hx);
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i].d !== frame[order[i]]) begin
        miscompares++;
        $display("FAIL signed[%0d] got %h want %h", i, q[i].d, frame[order[i]]);
      end
    end
  endtask

`ifdef BITREV_REORDER_BYPASS_EN
  task automatic test_bypass;
    int k;
    q.delete();
    bus.bypass = 1'b1;
    fill_ramp(0);
    send_frame(8, k);
    drive_idle(12);
    bus.bypass = 1'b0;
    drive_idle(10);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL bypass_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i].d[31:16] !== 16'(i) || q[i].s !== (i == 0) || q[i].c !== k + 9 + i) begin
        miscompares++;
        $display("FAIL bypass[%0d] got re=%0d s=%b c=%0d want re=%0d s=%b c=%0d",
                 i, q[i].d[31:16], q[i].s, q[i].c, i, (i == 0), k + 9 + i);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_signed();
`ifdef BITREV_REORDER_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
